// File: rtl/stream_pkg.sv
// Types and helpers shared by the stream multiplexer and its arbiter.
package stream_pkg;

  typedef enum logic [0:0] {ARB, LOCK} state_t;

  // Index width that stays at least one bit wide for degenerate channel counts.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational fixed-priority / round-robin arbiter with one-hot and encoded grant.
module rr_arbiter
  import stream_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter bit          RR_MODE = 1'b1,
  parameter int unsigned SEL_W   = sel_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  rr_ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              grant_any
);

  int unsigned idx;

  // An unknown request bit fails the if test, so it can never produce a grant.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = RR_MODE ? ((32'(rr_ptr) + k) % NUM_CH) : k;
      if (!grant_any) begin
        if (req[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = SEL_W'(idx);
          grant_any  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream mux with arbitration, packet locking and a registered output.
module stream_mux_arb
  import stream_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_CH  = 4,
  parameter bit          RR_MODE = 1'b1,
  parameter int unsigned SEL_W   = sel_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_last,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  state_t             state_q;
  logic [SEL_W-1:0]   rr_ptr_q;
  logic [SEL_W-1:0]   lock_ch_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_data_q;
  logic               out_last_q;
  logic [SEL_W-1:0]   out_sel_q;

  logic [NUM_CH-1:0]  lock_mask;
  logic [NUM_CH-1:0]  eligible;
  logic [NUM_CH-1:0]  grant;
  logic [SEL_W-1:0]   grant_idx;
  logic               grant_any;
  logic               load_en;
  logic               xfer;
  logic               sel_last;
  logic [WIDTH-1:0]   sel_data;
  logic [SEL_W-1:0]   ptr_next;
  logic [WIDTH-1:0]   ch_data [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_split
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  assign lock_mask = {{(NUM_CH-1){1'b0}}, 1'b1} << lock_ch_q;
  assign eligible  = (state_q == LOCK) ? (in_valid & lock_mask) : in_valid;

  rr_arbiter #(
    .NUM_CH  (NUM_CH),
    .RR_MODE (RR_MODE),
    .SEL_W   (SEL_W)
  ) u_arb (
    .req       (eligible),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // in_ready depends combinationally on out_ready through load_en.
  assign load_en  = !out_valid_q || out_ready;
  assign in_ready = {NUM_CH{load_en}} & grant;
  assign xfer     = load_en && grant_any;
  assign sel_data = ch_data[grant_idx];
  assign sel_last = in_last[grant_idx];
  assign ptr_next = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + SEL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      lock_ch_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      if (load_en) begin
        out_valid_q <= xfer;
      end
      if (xfer) begin
        out_data_q <= sel_data;
        out_last_q <= sel_last;
        out_sel_q  <= grant_idx;
        // The pointer only moves once a whole packet has been passed.
        case (state_q)
          ARB: begin
            if (!sel_last) begin
              state_q   <= LOCK;
              lock_ch_q <= grant_idx;
            end else begin
              rr_ptr_q <= ptr_next;
            end
          end
          LOCK: begin
            if (sel_last) begin
              state_q  <= ARB;
              rr_ptr_q <= ptr_next;
            end
          end
        endcase
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Self-checking bench for stream_mux_arb: round-robin and fixed-priority instances side by side.
module tb_stream_mux_arb;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   in_valid;
  logic [3:0]   in_last;
  logic [31:0]  d [N];
  logic [127:0] in_data;
  logic         out_ready;

  logic [3:0]   rdy_rr, rdy_fp;
  logic         ov_rr, ov_fp, ol_rr, ol_fp;
  logic [31:0]  od_rr, od_fp;
  logic [1:0]   os_rr, os_fp;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, index 0 = fixed priority, 1 = round robin.
  bit          m_ov   [2];
  logic [31:0] m_od   [2];
  bit          m_ol   [2];
  int          m_os   [2];
  int          m_ptr  [2];
  bit          m_lock [2];
  int          m_lch  [2];

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic [1:0] exp_sel;
  } vec_t;

  vec_t tbl [8];

  assign in_data = {d[3], d[2], d[1], d[0]};

  always #5 clk = ~clk;

  stream_mux_arb #(.WIDTH(32), .NUM_CH(4), .RR_MODE(1'b1)) dut_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (rdy_rr),
    .out_valid (ov_rr),
    .out_data  (od_rr),
    .out_last  (ol_rr),
    .out_sel   (os_rr),
    .out_ready (out_ready)
  );

  stream_mux_arb #(.WIDTH(32), .NUM_CH(4), .RR_MODE(1'b0)) dut_fp (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (rdy_fp),
    .out_valid (ov_fp),
    .out_data  (od_fp),
    .out_last  (ol_fp),
    .out_sel   (os_fp),
    .out_ready (out_ready)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ov[m] = 0; m_od[m] = '0; m_ol[m] = 0; m_os[m] = 0;
      m_ptr[m] = 0; m_lock[m] = 0; m_lch[m] = 0;
    end
  endtask

  // Channel the specification's rules select this cycle, or -1.
  function automatic int pick(input int m);
    int i;
    if (m_lock[m]) return (in_valid[m_lch[m]] === 1'b1) ? m_lch[m] : -1;
    for (int k = 0; k < N; k++) begin
      i = (m == 1) ? (m_ptr[m] + k) % N : k;
      if (in_valid[i] === 1'b1) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(input int m);
    int g;
    g = pick(m);
    if ((!m_ov[m] || out_ready === 1'b1) && g >= 0) return 4'(1 << g);
    return 4'b0000;
  endfunction

  task automatic model_step(input int m);
    int g;
    g = pick(m);
    if (!m_ov[m] || out_ready === 1'b1) begin
      m_ov[m] = (g >= 0);
      if (g >= 0) begin
        m_od[m] = d[g];
        m_ol[m] = in_last[g];
        m_os[m] = g;
        if (m_lock[m]) begin
          if (in_last[g]) begin
            m_lock[m] = 0;
            m_ptr[m]  = (g + 1) % N;
          end
        end else if (!in_last[g]) begin
          m_lock[m] = 1;
          m_lch[m]  = g;
        end else begin
          m_ptr[m] = (g + 1) % N;
        end
      end
    end
  endtask

  // Called just after a negedge with inputs driven; returns at the following negedge.
  task automatic tick();
    #1;
    check("rr in_ready", 32'(rdy_rr), 32'(exp_ready(1)));
    check("fp in_ready", 32'(rdy_fp), 32'(exp_ready(0)));
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
    check("rr out_valid", 32'(ov_rr), 32'(m_ov[1]));
    check("fp out_valid", 32'(ov_fp), 32'(m_ov[0]));
    if (m_ov[1]) begin
      check("rr out_data", od_rr, m_od[1]);
      check("rr out_last", 32'(ol_rr), 32'(m_ol[1]));
      check("rr out_sel", 32'(os_rr), 32'(m_os[1]));
    end
    if (m_ov[0]) begin
      check("fp out_data", od_fp, m_od[0]);
      check("fp out_last", 32'(ol_fp), 32'(m_ol[0]));
      check("fp out_sel", 32'(os_fp), 32'(m_os[0]));
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset out_valid", {30'd0, ov_fp, ov_rr}, 32'd0);
    check("reset out_sel", {28'd0, os_fp, os_rr}, 32'd0);
    check("reset out_data", od_rr | od_fp, 32'd0);
    check("reset out_last", {30'd0, ol_fp, ol_rr}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{4'hF, 4'hF, 1'b1, 4'b0001, 2'd0};
    tbl[1] = '{4'hF, 4'hF, 1'b1, 4'b0010, 2'd1};
    tbl[2] = '{4'hF, 4'hF, 1'b1, 4'b0100, 2'd2};
    tbl[3] = '{4'hF, 4'hF, 1'b1, 4'b1000, 2'd3};
    tbl[4] = '{4'hF, 4'hF, 1'b1, 4'b0001, 2'd0};
    tbl[5] = '{4'hF, 4'hF, 1'b1, 4'b0010, 2'd1};
    tbl[6] = '{4'hF, 4'hF, 1'b1, 4'b0100, 2'd2};
    tbl[7] = '{4'hF, 4'hF, 1'b1, 4'b1000, 2'd3};

    in_valid = '0; in_last = '0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) d[i] = 32'hA5A5_0000 + 32'(i);
    apply_reset();

    // Idle after reset release.
    out_ready = 1'b1;
    #1 check("idle in_ready", {24'd0, rdy_fp, rdy_rr}, 32'd0);
    tick();
    check("idle out_valid", 32'(ov_rr), 32'd0);

    // Round-robin fairness table.
    for (int i = 0; i < 8; i++) begin
      in_valid = tbl[i].v; in_last = tbl[i].l; out_ready = tbl[i].ordy;
      #1 check("tbl in_ready", 32'(rdy_rr), 32'(tbl[i].exp_rdy));
      tick();
      check("tbl out_sel", 32'(os_rr), 32'(tbl[i].exp_sel));
      check("tbl out_data", od_rr, 32'hA5A5_0000 + 32'(tbl[i].exp_sel));
    end

    // Fixed priority: ch1 beats ch3 until ch1 drops.
    apply_reset();
    in_valid = 4'b1010; in_last = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check("fp starve in_ready", 32'(rdy_fp), 32'h2);
      tick();
      check("fp starve out_sel", 32'(os_fp), 32'd1);
      check("fp starve out_data", od_fp, 32'hA5A5_0001);
    end
    in_valid = 4'b1000;
    #1 check("fp ch3 in_ready", 32'(rdy_fp), 32'h8);
    tick();
    check("fp ch3 out_sel", 32'(os_fp), 32'd3);

    // Packet lock: three-beat packet on ch2 while ch0 waits.
    apply_reset();
    out_ready = 1'b1;
    in_valid = 4'b0100; in_last = 4'b0000;
    #1 check("lock beat1 in_ready", 32'(rdy_rr), 32'h4);
    tick();
    check("lock beat1 out_sel", 32'(os_rr), 32'd2);
    in_valid = 4'b0101;
    #1 check("lock beat2 in_ready", 32'(rdy_rr), 32'h4);
    tick();
    check("lock beat2 out_sel", 32'(os_rr), 32'd2);
    in_last = 4'b0100;
    #1 check("lock beat3 in_ready", 32'(rdy_rr), 32'h4);
    tick();
    check("lock beat3 out_sel", 32'(os_rr), 32'd2);
    check("lock beat3 out_last", 32'(ol_rr), 32'd1);
    in_valid = 4'b1001; in_last = 4'hF;
    #1 check("lock ptr3 in_ready", 32'(rdy_rr), 32'h8);
    tick();
    check("lock ptr3 out_sel", 32'(os_rr), 32'd3);
    #1 check("lock wrap in_ready", 32'(rdy_rr), 32'h1);
    tick();
    check("lock wrap out_sel", 32'(os_rr), 32'd0);

    // Backpressure with hold, then same-cycle refill.
    apply_reset();
    out_ready = 1'b1; in_valid = 4'b0010; in_last = 4'hF; d[1] = 32'h5A5A_5A5A;
    tick();
    out_ready = 1'b0; in_valid = 4'b0001; d[0] = 32'h1111_2222;
    for (int i = 0; i < 5; i++) begin
      #1 check("hold in_ready", 32'(rdy_rr), 32'd0);
      tick();
      check("hold out_data", od_rr, 32'h5A5A_5A5A);
      check("hold out_valid", 32'(ov_rr), 32'd1);
    end
    out_ready = 1'b1;
    #1 check("refill in_ready", 32'(rdy_rr), 32'h1);
    tick();
    check("refill out_valid", 32'(ov_rr), 32'd1);
    check("refill out_data", od_rr, 32'h1111_2222);

    // Asynchronous reset mid-stream, between clock edges.
    check("pre-reset out_valid", 32'(ov_rr), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async out_valid", {30'd0, ov_fp, ov_rr}, 32'd0);
    check("async out_sel", {28'd0, os_fp, os_rr}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Unknown valid bit must not transfer.
    in_valid = 4'b00x0; out_ready = 1'b1;
    #1 check("x in_ready", {24'd0, rdy_fp, rdy_rr}, 32'd0);
    tick();
    check("x out_valid", {30'd0, ov_fp, ov_rr}, 32'd0);
    in_valid = '0;

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom) | 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) d[i] = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
